// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and scan-code constants for the PS/2 keyboard peripheral
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 pin conditioning, frame receiver and inter-bit watchdog
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_code_valid,
    output logic [7:0] o_code,
    output logic       o_frame_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic            r_clk_s1, r_clk_s2, r_clk_prev;
    logic            r_dat_s1, r_dat_s2;
    logic            r_fall, r_dat_q;
    rx_state_t       r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [WD_W-1:0] r_wd;

    // The fall is registered together with the data sample so both line up.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_fall     <= 1'b0;
            r_dat_q    <= 1'b1;
        end else begin
            r_clk_s1   <= i_ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= i_ps2_dat;
            r_dat_s2   <= r_dat_s1;
            r_fall     <= r_clk_prev & ~r_clk_s2;
            r_dat_q    <= r_dat_s2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_wd         <= '0;
            o_code_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_code_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            if (r_fall) begin
                r_wd <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_q) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        r_shift   <= {r_dat_q, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        r_parity <= r_dat_q;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (r_dat_q && (^{r_parity, r_shift})) begin
                            o_code_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_state != ST_IDLE) begin
                // A stalled keyboard must not leave a half-received byte pending forever.
                if (r_wd == WD_LAST) begin
                    r_state     <= ST_IDLE;
                    r_wd        <= '0;
                    o_frame_err <= 1'b1;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end
        end
    end

    assign o_code = r_shift;

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - scan-code decode, ASCII translation and Apple-II-style keyboard latch
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter logic [15:0] KBD_ADR        = 16'hC000,
    parameter logic [15:0] STROBE_ADR     = 16'hC010,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        CLOCK_50,
    input  logic        res,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic        phi,
    input  logic [15:0] adr,
    input  logic        rw,
    output logic [7:0]  dbo,
    output logic        sel,
    output logic        frame_err
);

    // Returns {hit, ascii}; hit = 0 for codes with no printable mapping.
    function automatic logic [7:0] translate(input logic [7:0] code, input logic shift,
                                             input logic ctrl);
        logic [6:0] a;
        logic       letter;
        a = 7'h00;
        case (code)
            8'h1C: a = 7'h41; 8'h32: a = 7'h42; 8'h21: a = 7'h43; 8'h23: a = 7'h44;
            8'h24: a = 7'h45; 8'h2B: a = 7'h46; 8'h34: a = 7'h47; 8'h33: a = 7'h48;
            8'h43: a = 7'h49; 8'h3B: a = 7'h4A; 8'h42: a = 7'h4B; 8'h4B: a = 7'h4C;
            8'h3A: a = 7'h4D; 8'h31: a = 7'h4E; 8'h44: a = 7'h4F; 8'h4D: a = 7'h50;
            8'h15: a = 7'h51; 8'h2D: a = 7'h52; 8'h1B: a = 7'h53; 8'h2C: a = 7'h54;
            8'h3C: a = 7'h55; 8'h2A: a = 7'h56; 8'h1D: a = 7'h57; 8'h22: a = 7'h58;
            8'h35: a = 7'h59; 8'h1A: a = 7'h5A;
            default: a = 7'h00;
        endcase
        letter = (a != 7'h00);
        if (!letter) begin
            case (code)
                8'h16: a = shift ? 7'h21 : 7'h31;
                8'h1E: a = shift ? 7'h40 : 7'h32;
                8'h26: a = shift ? 7'h23 : 7'h33;
                8'h25: a = shift ? 7'h24 : 7'h34;
                8'h2E: a = shift ? 7'h25 : 7'h35;
                8'h36: a = shift ? 7'h5E : 7'h36;
                8'h3D: a = shift ? 7'h26 : 7'h37;
                8'h3E: a = shift ? 7'h2A : 7'h38;
                8'h46: a = shift ? 7'h28 : 7'h39;
                8'h45: a = shift ? 7'h29 : 7'h30;
                8'h0E: a = shift ? 7'h7E : 7'h60;
                8'h4E: a = shift ? 7'h5F : 7'h2D;
                8'h55: a = shift ? 7'h2B : 7'h3D;
                8'h54: a = shift ? 7'h7B : 7'h5B;
                8'h5B: a = shift ? 7'h7D : 7'h5D;
                8'h5D: a = shift ? 7'h7C : 7'h5C;
                8'h4C: a = shift ? 7'h3A : 7'h3B;
                8'h52: a = shift ? 7'h22 : 7'h27;
                8'h41: a = shift ? 7'h3C : 7'h2C;
                8'h49: a = shift ? 7'h3E : 7'h2E;
                8'h4A: a = shift ? 7'h3F : 7'h2F;
                8'h29: a = 7'h20;
                8'h5A: a = 7'h0D;
                8'h66: a = 7'h08;
                8'h76: a = 7'h1B;
                default: a = 7'h00;
            endcase
        end
        if (ctrl && letter) begin
            a = a & 7'h1F;
        end
        return {(letter || a != 7'h00), a};
    endfunction

    logic       w_code_valid;
    logic [7:0] w_code;
    logic [7:0] w_xlat;
    logic       w_is_mod;
    logic       w_key;
    logic       w_strobe;

    logic       r_brk, r_ext;
    logic       r_lshift, r_rshift, r_ctrl;
    logic [7:0] r_latch;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk       (CLOCK_50),
        .i_resetn    (res),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_dat   (ps2_dat),
        .o_code_valid(w_code_valid),
        .o_code      (w_code),
        .o_frame_err (frame_err)
    );

    assign w_xlat   = translate(w_code, r_lshift | r_rshift, r_ctrl);
    assign w_is_mod = (w_code == SC_LSHIFT) || (w_code == SC_RSHIFT) || (w_code == SC_CTRL);
    assign w_key    = w_code_valid && !r_brk && !r_ext && !w_is_mod && w_xlat[7]
                      && (w_code != SC_BREAK) && (w_code != SC_EXT);
    assign w_strobe = phi && (adr == STROBE_ADR);

    always_ff @(posedge CLOCK_50) begin
        if (!res) begin
            r_brk    <= 1'b0;
            r_ext    <= 1'b0;
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_ctrl   <= 1'b0;
        end else if (w_code_valid) begin
            if (w_code == SC_BREAK) begin
                r_brk <= 1'b1;
            end else if (w_code == SC_EXT) begin
                r_ext <= 1'b1;
            end else begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
                if (w_code == SC_LSHIFT) r_lshift <= !r_brk;
                if (w_code == SC_RSHIFT) r_rshift <= !r_brk;
                if (w_code == SC_CTRL)   r_ctrl   <= !r_brk;
            end
        end
    end

    // A fresh key outranks a strobe clear landing on the same edge.
    always_ff @(posedge CLOCK_50) begin
        if (!res) begin
            r_latch <= 8'h00;
        end else if (w_key) begin
            r_latch <= {1'b1, w_xlat[6:0]};
        end else if (w_strobe) begin
            r_latch[7] <= 1'b0;
        end
    end

    assign sel = rw && ((adr == KBD_ADR) || (adr == STROBE_ADR));
    assign dbo = sel ? r_latch : 8'h00;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - self-checking bench for ps2_keyboard
module tb_ps2_keyboard;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic        phi = 1'b0;
    logic [15:0] adr = 16'hC000;
    logic        rw = 1'b1;
    logic [7:0]  dbo;
    logic        sel;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int n_err_pulses = 0;

    ps2_keyboard #(
        .KBD_ADR       (16'hC000),
        .STROBE_ADR    (16'hC010),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLOCK_50 (clk),
        .res      (res),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .phi      (phi),
        .adr      (adr),
        .rw       (rw),
        .dbo      (dbo),
        .sel      (sel),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) n_err_pulses++;
    end

    typedef struct {
        logic [7:0] code;
        int         mode;     // 0 good, 1 bad parity, 2 bad stop
        logic [7:0] exp_dbo;
        int         exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic ps2_bit(input logic b, input logic leave_low);
        ps2_dat = b;
        repeat (10) @(posedge clk);
        #1 ps2_clk = 1'b0;
        if (!leave_low) begin
            repeat (10) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
    endtask

    // Returns #1 after the edge that follows the last driven clock fall.
    task automatic send_bits(input logic [7:0] code, input int mode, input int nbits,
                             input logic leave_low);
        logic [10:0] bits;
        bits = {(mode != 2), (~^code) ^ (mode == 1), code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(bits[i], leave_low && (i == nbits - 1));
        end
    endtask

    task automatic finish_frame();
        repeat (10) @(posedge clk);
        #1 ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [7:0] c, input int m, input logic [7:0] d, input int e);
        vec_t v;
        v.code = c; v.mode = m; v.exp_dbo = d; v.exp_err = e;
        vecs.push_back(v);
    endtask

    initial begin
        int t;
        int e0;

        add_vec(8'h12, 0, 8'h41, 0);
        add_vec(8'h16, 0, 8'hA1, 0);
        add_vec(8'hF0, 0, 8'hA1, 0);
        add_vec(8'h16, 0, 8'hA1, 0);
        add_vec(8'hF0, 0, 8'hA1, 0);
        add_vec(8'h12, 0, 8'hA1, 0);
        add_vec(8'h16, 0, 8'hB1, 0);
        add_vec(8'h55, 1, 8'hB1, 1);
        add_vec(8'h29, 0, 8'hA0, 0);
        add_vec(8'h14, 0, 8'hA0, 0);
        add_vec(8'h21, 0, 8'h83, 0);
        add_vec(8'hF0, 0, 8'h83, 0);
        add_vec(8'h14, 0, 8'h83, 0);
        add_vec(8'h21, 0, 8'hC3, 0);
        add_vec(8'hE0, 0, 8'hC3, 0);
        add_vec(8'h75, 0, 8'hC3, 0);
        add_vec(8'h4E, 0, 8'hAD, 0);
        add_vec(8'h59, 0, 8'hAD, 0);
        add_vec(8'h4E, 0, 8'hDF, 0);
        add_vec(8'hF0, 0, 8'hDF, 0);
        add_vec(8'h59, 0, 8'hDF, 0);
        add_vec(8'h45, 0, 8'hB0, 0);
        add_vec(8'h66, 0, 8'h88, 0);
        add_vec(8'h76, 0, 8'h9B, 0);
        add_vec(8'h07, 0, 8'h9B, 0);
        add_vec(8'h1C, 2, 8'h9B, 1);

        // Reset state and address decode
        repeat (4) @(posedge clk);
        #1 res = 1'b1;
        #1;
        check("rst_dbo", dbo, 8'h00);
        check("rst_sel", sel, 1'b1);
        check("rst_err", frame_err, 1'b0);
        adr = 16'h1234;
        #1;
        check("other_sel", sel, 1'b0);
        check("other_dbo", dbo, 8'h00);
        adr = 16'hC000;

        // 'A' with latch latency, then strobe read
        send_bits(8'h1C, 0, 11, 1'b1);
        repeat (4) @(posedge clk);
        #1 check("a_lat_early", dbo, 8'h00);
        @(posedge clk);
        #1 check("a_lat", dbo, 8'hC1);
        phi = 1'b1; adr = 16'hC010;
        #1 check("strobe_read_sel", sel, 1'b1);
        check("strobe_read_dbo", dbo, 8'hC1);
        @(posedge clk);
        #1 phi = 1'b0; adr = 16'hC000;
        #1 check("after_strobe", dbo, 8'h41);
        finish_frame();

        // Parity error pulse timing
        e0 = n_err_pulses;
        send_bits(8'h33, 1, 11, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("perr_early", frame_err, 1'b0);
        @(posedge clk);
        #1 check("perr_pulse", frame_err, 1'b1);
        @(posedge clk);
        #1 check("perr_width", frame_err, 1'b0);
        finish_frame();
        check("perr_count", n_err_pulses - e0, 1);
        check("perr_latch", dbo, 8'h41);

        // Table of frames
        foreach (vecs[i]) begin
            e0 = n_err_pulses;
            send_bits(vecs[i].code, vecs[i].mode, 11, 1'b1);
            repeat (5) @(posedge clk);
            #1 check($sformatf("vec%0d_dbo", i), dbo, vecs[i].exp_dbo);
            finish_frame();
            check($sformatf("vec%0d_err", i), n_err_pulses - e0, vecs[i].exp_err);
        end

        // Watchdog: start + 3 data bits then silence
        e0 = n_err_pulses;
        send_bits(8'h5A, 0, 4, 1'b1);
        t = -1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (frame_err && t < 0) t = c;
        end
        checks++;
        if (t < 100 || t > 106) begin
            errors++;
            $display("FAIL timeout_cycles actual=%0d required=100..106", t);
        end
        check("timeout_count", n_err_pulses - e0, 1);
        finish_frame();
        send_bits(8'h5A, 0, 11, 1'b1);
        repeat (5) @(posedge clk);
        #1 check("after_timeout", dbo, 8'h8D);
        finish_frame();

        // Key latch and strobe write on the same edge
        send_bits(8'h1C, 0, 11, 1'b1);
        repeat (4) @(posedge clk);
        #1 phi = 1'b1; adr = 16'hC010; rw = 1'b0;
        #1 check("wr_sel", sel, 1'b0);
        check("wr_dbo", dbo, 8'h00);
        @(posedge clk);
        #1 phi = 1'b0; adr = 16'hC000; rw = 1'b1;
        #1 check("key_beats_strobe", dbo, 8'hC1);
        phi = 1'b1; adr = 16'hC010; rw = 1'b0;
        @(posedge clk);
        #1 phi = 1'b0; adr = 16'hC000; rw = 1'b1;
        #1 check("strobe_write", dbo, 8'h41);
        finish_frame();

        // Reset mid-frame with ctrl held
        send_bits(8'h14, 0, 11, 1'b1);
        finish_frame();
        e0 = n_err_pulses;
        send_bits(8'h3C, 0, 5, 1'b0);
        @(posedge clk);
        #1 res = 1'b0;
        repeat (2) @(posedge clk);
        #1 res = 1'b1;
        #1 check("midrst_latch", dbo, 8'h00);
        repeat (200) @(posedge clk);
        #1 check("midrst_no_err", n_err_pulses - e0, 0);
        send_bits(8'h1C, 0, 11, 1'b1);
        repeat (5) @(posedge clk);
        #1 check("midrst_ctrl_clear", dbo, 8'hC1);
        finish_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

Memory-mapped keyboard input peripheral for the 8-bit computer. It receives PS/2 (scan-code set 2) frames from a keyboard, translates make codes to 7-bit ASCII, and holds the result in an Apple-II-style keyboard latch. The 6502 reads that latch on the CPU bus. It is the input-side counterpart of the video/text output path and sits beside the RAM/ROM responders on `cpu_adr`/`cpu_dbi`.

## Interface
- `KBD_ADR`, 16'hC000, read address of the keyboard latch.
- `STROBE_ADR`, 16'hC010, any access here clears the strobe bit.
- `TIMEOUT_CYCLES`, 50000, number of CLOCK_50 cycles without a PS/2 clock fall before a partial frame is aborted (1 ms).

- `CLOCK_50`  in  1  sole clock.
- `res`  in  1  reset, synchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_dat`  in  1  raw PS/2 data pin, asynchronous.
- `phi`  in  1  one-CLOCK_50-cycle pulse marking the end of a CPU bus cycle.
- `adr`  in  16  CPU address bus.
- `rw`  in  1  1 = read, 0 = write.
- `dbo`  out  8  read data to the CPU data-in mux.
- `sel`  out  1  high when `dbo` is to be driven onto `cpu_dbi`.
- `frame_err`  out  1  one-cycle pulse on a parity, start or stop error, or on a timeout.

## Operation
- Input conditioning: 2-flop synchronizers on `ps2_clk` and `ps2_dat`. A fall is detected when the synced clock was 1 and is now 0.
- Frame FSM, advanced only on a detected fall:
  - IDLE: data 0 → DATA with bit count 0. Data 1 → stay in IDLE, no error.
  - DATA: shift in LSB first; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: if stop = 1 and the 9 bits have odd parity → emit `code_valid` with the byte. Otherwise pulse `frame_err`. Either way → IDLE.
- Watchdog: counter reloads on every fall. If it reaches TIMEOUT_CYCLES while not in IDLE → IDLE, byte discarded, `frame_err` pulsed.
- Scan-code decode, on each `code_valid`:
  - 0xF0 sets `brk`.
  - 0xE0 sets `ext`.
  - Any other code consumes and clears both flags.
  - Modifiers: 0x12/0x59 (shifts) and 0x14 (ctrl). A make sets the modifier; a code with `brk` set clears it.
  - Codes with `ext` or `brk` set are otherwise ignored.
  - Non-modifier make codes are translated. Unmapped codes are ignored.
- Translation:
  - Letters always map to uppercase 0x41–0x5A.
  - Digits and punctuation use the US layout, with the shifted variant when either shift is held.
  - Special keys: 0x29→0x20, 0x5A→0x0D, 0x66→0x08, 0x76→0x1B.
  - With ctrl held, letters give `ascii & 0x1F`.
- Latch: a translated key writes `{1'b1, ascii[6:0]}`, overwriting any unread key.
- Bus responder:
  - `sel = rw && (adr == KBD_ADR || adr == STROBE_ADR)`, combinational.
  - When `sel` is high, `dbo` = latch for either address. When `sel` is low, `dbo` = 0x00.
  - Any access (read or write) to STROBE_ADR with `phi` high clears latch bit 7 at the next edge. Bits 6:0 are kept.
- Simultaneous events: a new key latch and a strobe clear in the same cycle → the new key wins (bit 7 = 1).
- Reset (`res` = 0 at a clock edge): FSM → IDLE; bit count, watchdog, `brk`, `ext` and all modifiers cleared; latch = 0x00; `frame_err` = 0. Reset mid-frame discards the partial byte, with no error pulse.

## Timing
- A pin fall is detected 3 CLOCK_50 cycles later (two synchronizer flops plus the edge register).
- For a stop-bit fall detected at cycle E: `code_valid` is asserted at E+1 and the latch is visible on `dbo` from E+2.
- `frame_err` is high for exactly 1 cycle, at E+1, or on the watchdog expiry cycle.
- The strobe clear takes effect on the edge after the `phi` cycle. A read at KBD_ADR in that same `phi` cycle still sees bit 7 = 1.
- The bus path is combinational, with no wait states.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants SC_BREAK=0xF0, SC_EXT=0xE0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CTRL=0x14.
- Sub-module `ps2_rx`: synchronizers, edge detect, frame FSM and watchdog. Outputs `code_valid`, `code[7:0]` and `frame_err`.
- The top level holds the modifier state, the translation (a combinational case function) and the latch/bus logic.

## Test plan
- Reset, then read 0xC000 → `dbo` = 0x00 and `sel` = 1. Read 0x1234 → `sel` = 0.
- Send frame 0x1C ('A') with correct parity → `dbo` at 0xC000 = 0xC1, 2 cycles after the stop fall. Read 0xC010 with `phi` → the next read gives 0x41.
- Send 0x12, 0x16, 0xF0, 0x16, 0xF0, 0x12, 0x16 → latch is '!' (0xA1) after the 2nd make and '1' (0xB1) after the last.
- Send a frame with a wrong parity bit → one `frame_err` pulse, latch unchanged. A following valid 0x29 latches 0xA0.
- Send 3 data bits then stop clocking, with TIMEOUT_CYCLES=100 → `frame_err` pulse at 100 cycles. The next full frame 0x5A latches 0x8D.
- Key latch and strobe write in the same cycle → bit 7 = 1. Assert `res` mid-frame → no `frame_err`, latch = 0x00.
